// File: rtl/sii_ncu_xfer_mon_pkg.sv
// Shared state encoding, error-bit positions and header field layout for the
// SII->NCU inbound transfer monitor.
package sii_ncu_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REQ_WAIT = 2'd1,
    ST_PAYLOAD  = 2'd2
  } mon_state_t;

  localparam int ERR_PAR         = 0;
  localparam int ERR_GNT_NO_REQ  = 1;
  localparam int ERR_GNT_OVERLAP = 2;
  localparam int ERR_TIMEOUT     = 3;

  localparam int HDR_TYPE_MSB = 15;
  localparam int HDR_TYPE_LSB = 13;
  localparam int HDR_CPU_MSB  = 12;
  localparam int HDR_CPU_LSB  = 9;
  localparam int HDR_ID_MSB   = 8;
  localparam int HDR_ID_LSB   = 0;

  // Rebuild the packet header from its type, cpu/thread and id fields of beat 0.
  function automatic logic [15:0] hdr_extract(input logic [15:0] beat0);
    return {beat0[HDR_TYPE_MSB:HDR_TYPE_LSB],
            beat0[HDR_CPU_MSB:HDR_CPU_LSB],
            beat0[HDR_ID_MSB:HDR_ID_LSB]};
  endfunction

endpackage

// File: rtl/sii_ncu_xfer_mon_sat_counter.sv
// Saturating up-counter: adds 'inc' each cycle, sticks at all ones, and is
// cleared synchronously by 'clr'.
module sat_counter #(
  parameter int W     = 16,
  parameter int INC_W = 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [INC_W-1:0] inc,
  output logic [W-1:0]     count
);

  logic [W-1:0] r_count;
  logic [W:0]   w_sum;

  assign w_sum = {1'b0, r_count} + (W+1)'(inc);

  // Accumulate, clamping to all ones instead of wrapping on carry-out.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_count <= '0;
    end else if (w_sum[W]) begin
      r_count <= '1;
    end else begin
      r_count <= w_sum[W-1:0];
    end
  end

  assign count = r_count;

endmodule

// File: rtl/sii_ncu_xfer_mon.sv
// Passive monitor for the SII->NCU request/grant/payload interface: follows each
// transfer, captures header and payload, checks lane parity and ordering, and
// keeps sticky error flags plus saturating statistics.
module sii_ncu_xfer_mon
  import sii_ncu_mon_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int BEATS   = 4,
  parameter int PAR_W   = DATA_W / 16,
  parameter int TIMEOUT = 256,
  parameter int CNT_W   = 16
) (
  input  logic                    iol2clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    sii_ncu_req,
  input  logic                    ncu_sii_gnt,
  input  logic [DATA_W-1:0]       sii_ncu_data,
  input  logic [PAR_W-1:0]        sii_ncu_dparity,
  output logic                    pkt_vld,
  output logic [15:0]             pkt_hdr,
  output logic [BEATS*DATA_W-1:0] pkt_data,
  output logic [BEATS-1:0]        pkt_par_err,
  output logic [3:0]              err_flags,
  output logic [CNT_W-1:0]        req_cnt,
  output logic [CNT_W-1:0]        xfer_cnt,
  output logic [CNT_W-1:0]        err_cnt
);

  localparam int BI_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int WAIT_W = $clog2(TIMEOUT + 2);
  localparam logic [BI_W-1:0]   LAST_BEAT = BI_W'(BEATS - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = (TIMEOUT > 0) ? WAIT_W'(TIMEOUT - 1) : '0;

  mon_state_t              r_state;
  mon_state_t              w_nextState;
  logic [BI_W-1:0]         r_beatIdx;
  logic [BI_W-1:0]         w_nextBeatIdx;
  logic [BEATS*DATA_W-1:0] r_capData;
  logic [BEATS*DATA_W-1:0] w_mergedData;
  logic [BEATS-1:0]        r_capBad;
  logic [BEATS-1:0]        w_mergedBad;
  logic [PAR_W-1:0]        w_laneXor;
  logic                    w_beatBad;

  logic                    r_pktVld;
  logic [15:0]             r_pktHdr;
  logic [BEATS*DATA_W-1:0] r_pktData;
  logic [BEATS-1:0]        r_pktParErr;
  logic [3:0]              r_errFlags;

  logic                    w_reqEv;
  logic                    w_xferEv;
  logic                    w_evParErr;
  logic                    w_evGntNoReq;
  logic                    w_evOverlap;
  logic                    w_evTimeout;
  logic [2:0]              w_errInc;
  logic [WAIT_W-1:0]       w_waitCnt;
  logic                    w_waitClr;
  logic                    w_waitInc;

  // Recompute each 16-bit lane's even parity and flag the beat if any lane disagrees.
  always_comb begin
    w_laneXor = '0;
    for (int i = 0; i < PAR_W; i++) begin
      w_laneXor[i] = ^sii_ncu_data[16*i +: 16];
    end
    w_beatBad = |(w_laneXor ^ sii_ncu_dparity);
  end

  // Current beat merged into the capture buffer, so the final beat can be
  // published in the same cycle it arrives.
  always_comb begin
    w_mergedData = r_capData;
    w_mergedBad  = r_capBad;
    w_mergedData[int'(r_beatIdx)*DATA_W +: DATA_W] = sii_ncu_data;
    w_mergedBad[r_beatIdx] = w_beatBad;
  end

  // Transfer state machine and the per-cycle events it raises; a low enable
  // forces IDLE and suppresses every event.
  always_comb begin
    w_nextState   = r_state;
    w_nextBeatIdx = r_beatIdx;
    w_reqEv       = 1'b0;
    w_xferEv      = 1'b0;
    w_evParErr    = 1'b0;
    w_evGntNoReq  = 1'b0;
    w_evOverlap   = 1'b0;
    w_evTimeout   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_nextBeatIdx = '0;
        if (sii_ncu_req) begin
          w_reqEv     = 1'b1;
          w_nextState = ncu_sii_gnt ? ST_PAYLOAD : ST_REQ_WAIT;
        end else if (ncu_sii_gnt) begin
          w_evGntNoReq = 1'b1;
        end
      end
      ST_REQ_WAIT: begin
        w_nextBeatIdx = '0;
        if (ncu_sii_gnt) begin
          w_nextState = ST_PAYLOAD;
        end else if ((TIMEOUT != 0) && (w_waitCnt == WAIT_LAST)) begin
          w_evTimeout = 1'b1;
          w_nextState = ST_IDLE;
        end
      end
      ST_PAYLOAD: begin
        if (r_beatIdx == LAST_BEAT) begin
          w_xferEv      = 1'b1;
          w_evParErr    = |w_mergedBad;
          w_nextBeatIdx = '0;
          if (ncu_sii_gnt) begin
            w_reqEv     = 1'b1;
            w_nextState = ST_PAYLOAD;
          end else if (sii_ncu_req) begin
            w_reqEv     = 1'b1;
            w_nextState = ST_REQ_WAIT;
          end else begin
            w_nextState = ST_IDLE;
          end
        end else begin
          w_nextBeatIdx = r_beatIdx + 1'b1;
          w_evOverlap   = ncu_sii_gnt;
        end
      end
      default: begin
        w_nextState   = ST_IDLE;
        w_nextBeatIdx = '0;
      end
    endcase
    if (!enable) begin
      w_nextState   = ST_IDLE;
      w_nextBeatIdx = '0;
      w_reqEv       = 1'b0;
      w_xferEv      = 1'b0;
      w_evParErr    = 1'b0;
      w_evGntNoReq  = 1'b0;
      w_evOverlap   = 1'b0;
      w_evTimeout   = 1'b0;
    end
  end

  // State, capture buffer, registered packet outputs and sticky error flags.
  always_ff @(posedge iol2clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_beatIdx   <= '0;
      r_capData   <= '0;
      r_capBad    <= '0;
      r_pktVld    <= 1'b0;
      r_pktHdr    <= '0;
      r_pktData   <= '0;
      r_pktParErr <= '0;
      r_errFlags  <= '0;
    end else begin
      r_state   <= w_nextState;
      r_beatIdx <= w_nextBeatIdx;
      if ((r_state == ST_PAYLOAD) && enable) begin
        r_capData <= w_mergedData;
        r_capBad  <= w_mergedBad;
      end
      r_pktVld <= w_xferEv;
      if (w_xferEv) begin
        r_pktHdr    <= hdr_extract(w_mergedData[15:0]);
        r_pktData   <= w_mergedData;
        r_pktParErr <= w_mergedBad;
      end
      r_errFlags[ERR_PAR]         <= r_errFlags[ERR_PAR]         | w_evParErr;
      r_errFlags[ERR_GNT_NO_REQ]  <= r_errFlags[ERR_GNT_NO_REQ]  | w_evGntNoReq;
      r_errFlags[ERR_GNT_OVERLAP] <= r_errFlags[ERR_GNT_OVERLAP] | w_evOverlap;
      r_errFlags[ERR_TIMEOUT]     <= r_errFlags[ERR_TIMEOUT]     | w_evTimeout;
    end
  end

  assign w_errInc  = 3'(w_evParErr) + 3'(w_evGntNoReq) + 3'(w_evOverlap) + 3'(w_evTimeout);
  assign w_waitClr = rst | (r_state != ST_REQ_WAIT) | ~enable;
  assign w_waitInc = (r_state == ST_REQ_WAIT);

  sat_counter #(.W(CNT_W), .INC_W(1)) u_reqCnt (
    .clk(iol2clk), .clr(rst), .inc(w_reqEv), .count(req_cnt)
  );

  sat_counter #(.W(CNT_W), .INC_W(1)) u_xferCnt (
    .clk(iol2clk), .clr(rst), .inc(w_xferEv), .count(xfer_cnt)
  );

  sat_counter #(.W(CNT_W), .INC_W(3)) u_errCnt (
    .clk(iol2clk), .clr(rst), .inc(w_errInc), .count(err_cnt)
  );

  sat_counter #(.W(WAIT_W), .INC_W(1)) u_waitCnt (
    .clk(iol2clk), .clr(w_waitClr), .inc(w_waitInc), .count(w_waitCnt)
  );

  assign pkt_vld     = r_pktVld;
  assign pkt_hdr     = r_pktHdr;
  assign pkt_data    = r_pktData;
  assign pkt_par_err = r_pktParErr;
  assign err_flags   = r_errFlags;

endmodule

// File: tb/tb_sii_ncu_xfer_mon.sv
// Bench for sii_ncu_xfer_mon: a default 32-bit/4-beat instance and a
// 64-bit/2-beat instance with a short timeout, driven by directed vectors.
// Expected packets go into per-instance queues; a monitor pops them on pkt_vld.
`timescale 1ns/1ps
module tb_sii_ncu_xfer_mon;

  typedef struct {
    logic [15:0]  hdr;
    logic [127:0] data;
    logic [3:0]   parErr;
    int           cyc;
  } exp_t;

  logic clock = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  exp_t qA[$];
  exp_t qB[$];
  exp_t eA;
  exp_t eB;

  logic [63:0] beatVal[4];
  logic [3:0]  flip[4];
  logic        ovl[4];

  logic         rstA, enA, reqA, gntA;
  logic [31:0]  dataA;
  logic [1:0]   parA;
  logic         pktVldA;
  logic [15:0]  pktHdrA;
  logic [127:0] pktDataA;
  logic [3:0]   pktParErrA;
  logic [3:0]   errFlagsA;
  logic [15:0]  reqCntA, xferCntA, errCntA;

  logic         rstB, enB, reqB, gntB;
  logic [63:0]  dataB;
  logic [3:0]   parB;
  logic         pktVldB;
  logic [15:0]  pktHdrB;
  logic [127:0] pktDataB;
  logic [1:0]   pktParErrB;
  logic [3:0]   errFlagsB;
  logic [15:0]  reqCntB, xferCntB, errCntB;

  // Free-running clock
  always #5 clock = ~clock;

  // Cycle stamp, advanced on each active edge
  always @(posedge clock) cyc <= cyc + 1;

  sii_ncu_xfer_mon #(.DATA_W(32), .BEATS(4), .TIMEOUT(256), .CNT_W(16)) dutA (
    .iol2clk(clock), .rst(rstA), .enable(enA),
    .sii_ncu_req(reqA), .ncu_sii_gnt(gntA),
    .sii_ncu_data(dataA), .sii_ncu_dparity(parA),
    .pkt_vld(pktVldA), .pkt_hdr(pktHdrA), .pkt_data(pktDataA),
    .pkt_par_err(pktParErrA), .err_flags(errFlagsA),
    .req_cnt(reqCntA), .xfer_cnt(xferCntA), .err_cnt(errCntA)
  );

  sii_ncu_xfer_mon #(.DATA_W(64), .BEATS(2), .TIMEOUT(8), .CNT_W(16)) dutB (
    .iol2clk(clock), .rst(rstB), .enable(enB),
    .sii_ncu_req(reqB), .ncu_sii_gnt(gntB),
    .sii_ncu_data(dataB), .sii_ncu_dparity(parB),
    .pkt_vld(pktVldB), .pkt_hdr(pktHdrB), .pkt_data(pktDataB),
    .pkt_par_err(pktParErrB), .err_flags(errFlagsB),
    .req_cnt(reqCntB), .xfer_cnt(xferCntB), .err_cnt(errCntB)
  );

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] lanePar(input logic [63:0] d);
    logic [3:0] p;
    for (int i = 0; i < 4; i++) p[i] = ^d[16*i +: 16];
    return p;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic driveSlot(input int dut, input logic req, input logic gnt,
                           input logic [63:0] d, input logic [3:0] fl);
    logic [3:0] p;
    p = lanePar(d) ^ fl;
    if (dut == 0) begin
      reqA = req; gntA = gnt; dataA = d[31:0]; parA = p[1:0];
    end else begin
      reqB = req; gntB = gnt; dataB = d; parB = p;
    end
  endtask

  task automatic setBeats(input logic [63:0] b0, input logic [63:0] b1,
                          input logic [63:0] b2, input logic [63:0] b3);
    beatVal[0] = b0; beatVal[1] = b1; beatVal[2] = b2; beatVal[3] = b3;
    for (int i = 0; i < 4; i++) begin
      flip[i] = 4'h0;
      ovl[i]  = 1'b0;
    end
  endtask

  // Hold req for waitCycles (0 = request and grant together), then grant once.
  task automatic requestGrant(input int dut, input int waitCycles, output int tGnt);
    if (waitCycles > 0) begin
      driveSlot(dut, 1'b1, 1'b0, 64'h0, 4'h0);
      repeat (waitCycles) tick();
    end
    driveSlot(dut, (waitCycles == 0), 1'b1, 64'h0, 4'h0);
    tGnt = cyc;
    tick();
  endtask

  // Push the expected packet, then drive its beats after the grant at tGnt.
  task automatic applyStimulus(input int dut, input int tGnt, input int nb, input logic lastGnt);
    exp_t e;
    e.data   = '0;
    e.parErr = '0;
    for (int i = 0; i < nb; i++) begin
      if (dut == 0) e.data[i*32 +: 32] = beatVal[i][31:0];
      else          e.data[i*64 +: 64] = beatVal[i];
      e.parErr[i] = |flip[i];
    end
    e.hdr = beatVal[0][15:0];
    e.cyc = tGnt + 1 + nb;
    if (dut == 0) qA.push_back(e);
    else          qB.push_back(e);
    for (int i = 0; i < nb; i++) begin
      driveSlot(dut, 1'b0, (i == nb - 1) ? lastGnt : ovl[i], beatVal[i], flip[i]);
      tick();
    end
    driveSlot(dut, 1'b0, 1'b0, 64'h0, 4'h0);
  endtask

  task automatic checkCounts(input int dut, input string tag, input int rq, input int xf,
                             input int er, input logic [3:0] fl);
    if (dut == 0) begin
      checkOutput({tag, "_req_cnt"},   128'(reqCntA),   128'(rq));
      checkOutput({tag, "_xfer_cnt"},  128'(xferCntA),  128'(xf));
      checkOutput({tag, "_err_cnt"},   128'(errCntA),   128'(er));
      checkOutput({tag, "_err_flags"}, 128'(errFlagsA), 128'(fl));
    end else begin
      checkOutput({tag, "_req_cnt"},   128'(reqCntB),   128'(rq));
      checkOutput({tag, "_xfer_cnt"},  128'(xferCntB),  128'(xf));
      checkOutput({tag, "_err_cnt"},   128'(errCntB),   128'(er));
      checkOutput({tag, "_err_flags"}, 128'(errFlagsB), 128'(fl));
    end
  endtask

  task automatic checkReset(input int dut, input string tag);
    if (dut == 0) begin
      checkOutput({tag, "_pkt_vld"},     128'(pktVldA),    128'(0));
      checkOutput({tag, "_pkt_hdr"},     128'(pktHdrA),    128'(0));
      checkOutput({tag, "_pkt_data"},    pktDataA,         128'(0));
      checkOutput({tag, "_pkt_par_err"}, 128'(pktParErrA), 128'(0));
    end else begin
      checkOutput({tag, "_pkt_vld"},     128'(pktVldB),    128'(0));
      checkOutput({tag, "_pkt_hdr"},     128'(pktHdrB),    128'(0));
      checkOutput({tag, "_pkt_data"},    pktDataB,         128'(0));
      checkOutput({tag, "_pkt_par_err"}, 128'(pktParErrB), 128'(0));
    end
    checkCounts(dut, tag, 0, 0, 0, 4'b0000);
  endtask

  // Scoreboard monitor: each strobe must match the oldest queued packet, including its cycle
  always @(negedge clock) begin
    if (pktVldA === 1'b1) begin
      if (qA.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL A_unexpected_pkt: got pkt_vld=1 at cycle %0d, expected no strobe", cyc);
      end else begin
        eA = qA.pop_front();
        checkOutput("A_pkt_cycle",   128'(cyc),        128'(eA.cyc));
        checkOutput("A_pkt_hdr",     128'(pktHdrA),    128'(eA.hdr));
        checkOutput("A_pkt_data",    pktDataA,         eA.data);
        checkOutput("A_pkt_par_err", 128'(pktParErrA), 128'(eA.parErr));
      end
    end
    if (pktVldB === 1'b1) begin
      if (qB.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL B_unexpected_pkt: got pkt_vld=1 at cycle %0d, expected no strobe", cyc);
      end else begin
        eB = qB.pop_front();
        checkOutput("B_pkt_cycle",   128'(cyc),        128'(eB.cyc));
        checkOutput("B_pkt_hdr",     128'(pktHdrB),    128'(eB.hdr));
        checkOutput("B_pkt_data",    pktDataB,         eB.data);
        checkOutput("B_pkt_par_err", 128'(pktParErrB), 128'(eB.parErr));
      end
    end
  end

  // Directed scenario sequence
  initial begin
    int t;
    rstA = 1'b1; rstB = 1'b1; enA = 1'b1; enB = 1'b1;
    driveSlot(0, 1'b0, 1'b0, 64'h0, 4'h0);
    driveSlot(1, 1'b0, 1'b0, 64'h0, 4'h0);
    setBeats(64'h0, 64'h0, 64'h0, 64'h0);
    repeat (3) tick();
    checkReset(0, "A_reset");
    checkReset(1, "B_reset");
    rstA = 1'b0; rstB = 1'b0;
    tick();

    $display("[TB] single transfer");
    setBeats(64'h0000A123, 64'h11111111, 64'h22222222, 64'h33333333);
    requestGrant(0, 3, t);
    applyStimulus(0, t, 4, 1'b0);
    repeat (2) tick();
    checkCounts(0, "A_single", 1, 1, 0, 4'b0000);
    checkOutput("A_hdr_hold", 128'(pktHdrA), 128'(16'hA123));

    $display("[TB] parity error on beat2 upper lane");
    setBeats(64'h0000B456, 64'h44444444, 64'h55555555, 64'h66666666);
    flip[2] = 4'b0010;
    requestGrant(0, 1, t);
    applyStimulus(0, t, 4, 1'b0);
    repeat (2) tick();
    checkCounts(0, "A_parity", 2, 2, 1, 4'b0001);

    $display("[TB] back-to-back");
    setBeats(64'h00001234, 64'hDEADBEEF, 64'hCAFEF00D, 64'h01020304);
    requestGrant(0, 0, t);
    applyStimulus(0, t, 4, 1'b1);
    setBeats(64'h00005678, 64'h0BADC0DE, 64'hFFFF0000, 64'h8000_0001);
    applyStimulus(0, t + 4, 4, 1'b0);
    repeat (2) tick();
    checkCounts(0, "A_b2b", 4, 4, 1, 4'b0001);

    $display("[TB] grant without request");
    driveSlot(0, 1'b0, 1'b1, 64'h0, 4'h0);
    tick();
    driveSlot(0, 1'b0, 1'b0, 64'h0, 4'h0);
    tick();
    checkCounts(0, "A_gnt_no_req", 4, 4, 2, 4'b0011);

    $display("[TB] grant overlap on beat1");
    setBeats(64'h0000E001, 64'h12345678, 64'h9ABCDEF0, 64'h0F0F0F0F);
    ovl[1] = 1'b1;
    requestGrant(0, 2, t);
    applyStimulus(0, t, 4, 1'b0);
    repeat (2) tick();
    checkCounts(0, "A_overlap", 5, 5, 3, 4'b0111);

    $display("[TB] enable drop on beat1");
    setBeats(64'h0000AAAA, 64'hBBBBBBBB, 64'hCCCCCCCC, 64'hDDDDDDDD);
    requestGrant(0, 1, t);
    driveSlot(0, 1'b0, 1'b0, beatVal[0], 4'h0);
    tick();
    enA = 1'b0;
    driveSlot(0, 1'b0, 1'b0, beatVal[1], 4'h0);
    tick();
    enA = 1'b1;
    driveSlot(0, 1'b0, 1'b0, 64'h0, 4'h0);
    repeat (6) tick();
    checkCounts(0, "A_en_drop", 6, 5, 3, 4'b0111);
    setBeats(64'h00007FFF, 64'h13579BDF, 64'h2468ACE0, 64'h55AA55AA);
    requestGrant(0, 1, t);
    applyStimulus(0, t, 4, 1'b0);
    repeat (2) tick();
    checkCounts(0, "A_after_en", 7, 6, 3, 4'b0111);

    $display("[TB] reset on beat1");
    setBeats(64'h0000C0C0, 64'h77777777, 64'h88888888, 64'h99999999);
    requestGrant(0, 1, t);
    driveSlot(0, 1'b0, 1'b0, beatVal[0], 4'h0);
    tick();
    rstA = 1'b1;
    driveSlot(0, 1'b0, 1'b0, beatVal[1], 4'h0);
    tick();
    checkReset(0, "A_mid_reset");
    rstA = 1'b0;
    driveSlot(0, 1'b0, 1'b0, 64'h0, 4'h0);
    repeat (6) tick();
    setBeats(64'h00002B3C, 64'hA5A5A5A5, 64'h3C3C3C3C, 64'hF00DFACE);
    requestGrant(0, 2, t);
    applyStimulus(0, t, 4, 1'b0);
    repeat (2) tick();
    checkCounts(0, "A_after_reset", 1, 1, 0, 4'b0000);

    $display("[TB] timeout on 64-bit instance");
    driveSlot(1, 1'b1, 1'b0, 64'h0, 4'h0);
    repeat (8) tick();
    checkCounts(1, "B_pre_timeout", 1, 0, 0, 4'b0000);
    tick();
    checkCounts(1, "B_timeout", 1, 0, 1, 4'b1000);
    tick();
    checkOutput("B_rereq_cnt", 128'(reqCntB), 128'(2));
    setBeats(64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 64'h0, 64'h0);
    driveSlot(1, 1'b0, 1'b1, 64'h0, 4'h0);
    t = cyc;
    tick();
    applyStimulus(1, t, 2, 1'b0);
    repeat (2) tick();
    checkCounts(1, "B_clean", 2, 1, 1, 4'b1000);

    $display("[TB] 64-bit lane3 parity error");
    setBeats(64'h1111222233334C5D, 64'h8000000000000001, 64'h0, 64'h0);
    flip[1] = 4'b1000;
    requestGrant(1, 1, t);
    applyStimulus(1, t, 2, 1'b0);
    repeat (2) tick();
    checkCounts(1, "B_parity", 3, 2, 2, 4'b1001);

    repeat (4) tick();
    checkOutput("A_queue_drained", 128'(qA.size()), 128'(0));
    checkOutput("B_queue_drained", 128'(qB.size()), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sii_ncu_xfer_mon.md
# sii_ncu_xfer_mon

Synthesizable, parametrised monitor for the SII→NCU inbound request/grant/payload interface (Mondo interrupts, PIO completions). It sits passively on `sii_ncu_req`, `ncu_sii_gnt`, `sii_ncu_data` and `sii_ncu_dparity` in the `iol2clk` domain. It tracks each transfer through a state machine and captures the header and the full multi-beat payload. It checks per-lane parity and protocol ordering, and exposes a captured-packet strobe, sticky error flags and saturating statistics counters.

## Interface
- `DATA_W`, 32, payload beat width; must be a multiple of 16.
- `BEATS`, 4, payload beats per transfer, ≥1.
- `PAR_W`, `DATA_W/16`, parity bits per beat, one per 16-bit lane.
- `TIMEOUT`, 256, max REQ_WAIT cycles before timeout error; 0 disables the check.
- `CNT_W`, 16, statistics counter width.

Ports:
- `iol2clk`  in  1  clock; one clock domain only.
- `rst`  in  1  synchronous, active-high reset.
- `enable`  in  1  monitoring enable; when low the FSM is held in IDLE and no counts are made.
- `sii_ncu_req`  in  1  SII request, level.
- `ncu_sii_gnt`  in  1  NCU grant, single-cycle pulse.
- `sii_ncu_data`  in  DATA_W  payload beat.
- `sii_ncu_dparity`  in  PAR_W  even parity per lane.
- `pkt_vld`  out  1  one-cycle strobe; captured packet is valid.
- `pkt_hdr`  out  16  beat0[15:0].
- `pkt_data`  out  BEATS*DATA_W  beat0 in the LSBs.
- `pkt_par_err`  out  BEATS  per-beat parity-error mask.
- `err_flags`  out  4  sticky flags {timeout, gnt_overlap, gnt_no_req, par}.
- `req_cnt`, `xfer_cnt`, `err_cnt`  out  CNT_W each  saturating counters.

## Operation
- States: IDLE, REQ_WAIT, PAYLOAD.
- IDLE:
  - `req`=1 & `gnt`=0 → REQ_WAIT; `req_cnt`++.
  - `req`=1 & `gnt`=1 → PAYLOAD; `req_cnt`++.
  - `gnt`=1 & `req`=0 → set gnt_no_req; `err_cnt`++; stay in IDLE.
- REQ_WAIT: `gnt`=1 → PAYLOAD with the beat counter cleared. The wait counter increments each cycle. When it reaches `TIMEOUT` (nonzero), set timeout, `err_cnt`++, and return to IDLE. The `req` level is ignored in this state.
- PAYLOAD: capture one beat per cycle into slot `beat_idx`.
  - Parity check for lane i: `dparity[i]` ≠ ^`data[16i+15:16i]` marks the beat bad.
  - On the last beat (`beat_idx`=BEATS-1), the next cycle `pkt_vld`=1 and `xfer_cnt`++. If any beat was bad, also set par and `err_cnt`++ (once per packet).
- Last-beat exits from PAYLOAD:
  - `gnt`=1 on the last beat → back-to-back: stay in PAYLOAD with beat 0 next; this counts as a request (`req_cnt`++).
  - Else `req`=1 → REQ_WAIT; `req_cnt`++.
  - Else → IDLE.
- `gnt`=1 on a non-final PAYLOAD beat → set gnt_overlap, `err_cnt`++; the grant is ignored and the capture continues.
- Counters saturate at all ones and never wrap. `err_flags` clear only on `rst`.
- `enable` falling mid-transfer aborts the transfer: FSM → IDLE, no `pkt_vld`, partial data discarded.

## Timing
- Grant at cycle t → beats sampled at t+1 … t+BEATS → `pkt_vld` at t+BEATS+1.
- Back-to-back grant at t+BEATS → next beats start at t+BEATS+1. `pkt_vld` of the first packet coincides with beat 0 of the second; the `pkt_*` outputs are registered and hold until the next `pkt_vld`.
- Reset values: `pkt_vld`=0, `pkt_hdr`=0, `pkt_data`=0, `pkt_par_err`=0, `err_flags`=0, all counters 0, FSM=IDLE.
- Reset asserted mid-PAYLOAD: next cycle everything is at reset values and no strobe is produced.
- Simultaneous error and `pkt_vld` events in one cycle: `err_cnt` increments by the number of distinct errors, capped at saturation.

## Structure
- Package `sii_ncu_mon_pkg` holds:
  - the state enum `mon_state_t`;
  - error-bit index constants `ERR_PAR`=0, `ERR_GNT_NO_REQ`=1, `ERR_GNT_OVERLAP`=2, `ERR_TIMEOUT`=3;
  - the header field localparams: type [15:13], cpu/thread [12:9], id [8:0].
- Sub-module `sat_counter` (parameter W, inputs inc/clr, saturating) is instantiated for the three counters and the wait counter.

## Test plan
- Single transfer with defaults:
  - Stimulus: `req`↑ at cycle 2, `gnt` at cycle 5, beats 0x0000A123, 0x11111111, 0x22222222, 0x33333333 with correct parity.
  - Response: `pkt_vld` at cycle 10, `pkt_hdr`=0xA123, `req_cnt`=`xfer_cnt`=1, `err_flags`=0.
- Parity error: beat2 upper-lane parity flipped → `pkt_par_err`=4'b0100, `err_flags`[0]=1, `err_cnt`=1.
- Back-to-back: grant on the last beat twice → two `pkt_vld` strobes exactly 4 cycles apart, `xfer_cnt`=2, no errors.
- Protocol errors:
  - Grant with `req` low in IDLE → gnt_no_req set.
  - Grant on beat1 → gnt_overlap set; the packet still completes.
- Timeout: `TIMEOUT`=8, `req` held high with no grant → timeout set at the 8th wait cycle, FSM back to IDLE, `req_cnt` increments again on the next cycle (because `req` is still high).
- Reset or `enable` drop on beat1 → no `pkt_vld`. A fresh transfer afterwards captures correctly. A parametrised run with `DATA_W`=64, `BEATS`=2 checks 4-lane parity and a 128-bit `pkt_data`.
